rate_ctrl: RTL and testbench

Run/stop and rate-select controller for a 50%-duty divided clock. It is built around an internal half-period counter and a table of four compile-time divisors. Rate changes and stops take effect only on period boundaries, so `clk_out` never glitches or produces a runt phase. Downstream logic uses `clk_out` as a slow enable-style clock, uses `tick` as a one-cycle strobe in the `clk_in` domain, and uses `tick_cnt` for event counting.

---
 rtl/rate_ctrl.sv | 162 ++++++++++++++++
 tb/tb_rate_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_ctrl.sv
// rate_ctrl: run/stop and rate-select controller for a glitch-free 50%-duty divided clock.
// Optional macro RATE_BURST_EN adds burst_len, which auto-stops a run after N periods.
module rate_ctrl #(
    parameter logic [31:0] DIV0 = 32'd6000000,
    parameter logic [31:0] DIV1 = 32'd3000000,
    parameter logic [31:0] DIV2 = 32'd1500000,
    parameter logic [31:0] DIV3 = 32'd750000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  sel,
`ifdef RATE_BURST_EN
    input  logic [7:0]  burst_len,
`endif
    output logic        clk_out,
    output logic        tick,
    output logic        running,
    output logic [1:0]  sel_active,
    output logic [15:0] tick_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StStopPend} state_e;

    function automatic logic [31:0] half_of(input logic [31:0] div);
        logic [31:0] h;
        h = div >> 1;
        return (h == 32'd0) ? 32'd1 : h;
    endfunction

    localparam logic [31:0] Half0 = half_of(DIV0);
    localparam logic [31:0] Half1 = half_of(DIV1);
    localparam logic [31:0] Half2 = half_of(DIV2);
    localparam logic [31:0] Half3 = half_of(DIV3);

    state_e      r_state, w_state_d;
    logic [31:0] r_cnt, w_cnt_d;
    logic        r_clk_out, w_clk_out_d;
    logic        r_tick, w_tick_d;
    logic [1:0]  r_sel_active, w_sel_active_d;
    logic [15:0] r_tick_cnt, w_tick_cnt_d;

    logic [31:0] w_half;
    logic        w_term;
    logic        w_boundary;
    logic        w_start_req;
    logic        w_cancel;
    logic        w_burst_done;

`ifdef RATE_BURST_EN
    logic [7:0] r_pcnt, w_pcnt_d;
    logic [7:0] r_blen, w_blen_d;

    // The boundary being processed is period number r_pcnt + 1 of this run.
    assign w_burst_done = (r_blen != 8'd0) && ((r_pcnt + 8'd1) == r_blen);
`else
    assign w_burst_done = 1'b0;
`endif

    always_comb begin
        case (r_sel_active)
            2'd0:    w_half = Half0;
            2'd1:    w_half = Half1;
            2'd2:    w_half = Half2;
            default: w_half = Half3;
        endcase
    end

    assign w_term      = (r_cnt >= (w_half - 32'd1));
    assign w_boundary  = w_term & r_clk_out;
    assign w_start_req = start & ~stop;
    assign w_cancel    = (r_state == StStopPend) & w_start_req;

    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_clk_out_d    = r_clk_out;
        w_tick_d       = 1'b0;
        w_sel_active_d = r_sel_active;
        w_tick_cnt_d   = r_tick_cnt;
`ifdef RATE_BURST_EN
        w_pcnt_d       = r_pcnt;
        w_blen_d       = r_blen;
`endif
        case (r_state)
            StIdle: begin
                if (w_start_req) begin
                    w_state_d      = StRun;
                    w_cnt_d        = 32'd0;
                    w_sel_active_d = sel;
`ifdef RATE_BURST_EN
                    w_pcnt_d       = 8'd0;
                    w_blen_d       = burst_len;
`endif
                end
            end
            StRun, StStopPend: begin
                w_cnt_d = w_term ? 32'd0 : (r_cnt + 32'd1);
                if (w_term) begin
                    w_clk_out_d = ~r_clk_out;
                    if (!r_clk_out) begin
                        w_tick_d     = 1'b1;
                        w_tick_cnt_d = r_tick_cnt + 16'd1;
                    end
                end
                if (r_state == StRun) begin
                    if (stop) begin
                        w_state_d = StStopPend;
                    end
                end else if (w_cancel) begin
                    w_state_d = StRun;
                end
                // Falling edge of clk_out: the only point where rate or run state may change.
                if (w_boundary) begin
`ifdef RATE_BURST_EN
                    w_pcnt_d = r_pcnt + 8'd1;
`endif
                    if (((r_state == StStopPend) && !w_cancel) || w_burst_done) begin
                        w_state_d = StIdle;
                    end else begin
                        w_sel_active_d = sel;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= 32'd0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
            r_sel_active <= 2'd0;
            r_tick_cnt   <= 16'd0;
`ifdef RATE_BURST_EN
            r_pcnt       <= 8'd0;
            r_blen       <= 8'd0;
`endif
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_clk_out    <= w_clk_out_d;
            r_tick       <= w_tick_d;
            r_sel_active <= w_sel_active_d;
            r_tick_cnt   <= w_tick_cnt_d;
`ifdef RATE_BURST_EN
            r_pcnt       <= w_pcnt_d;
            r_blen       <= w_blen_d;
`endif
        end
    end

    assign clk_out    = r_clk_out;
    assign tick       = r_tick;
    assign running    = (r_state != StIdle);
    assign sel_active = r_sel_active;
    assign tick_cnt   = r_tick_cnt;

endmodule

// File: tb/tb_rate_ctrl.sv
// Self-checking bench for rate_ctrl: directed vector table, reset/wrap/burst sequences and
// randomized stimulus against a period-position reference model.
module tb_rate_ctrl;

    logic        clk;
    logic        rst_n;
    logic        st;
    logic        sp;
    logic [1:0]  sl;
    logic [7:0]  blen;
    logic        clk_out;
    logic        tick;
    logic        running;
    logic [1:0]  sel_active;
    logic [15:0] tick_cnt;

    int checks = 0;
    int errors = 0;

    rate_ctrl #(
        .DIV0(32'd4),
        .DIV1(32'd6),
        .DIV2(32'd8),
        .DIV3(32'd3)
    ) dut (
        .clk_in    (clk),
        .rst_n     (rst_n),
        .start     (st),
        .stop      (sp),
        .sel       (sl),
`ifdef RATE_BURST_EN
        .burst_len (blen),
`endif
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running),
        .sel_active(sel_active),
        .tick_cnt  (tick_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the current output period (0 .. 2*half-1).
    bit          m_run;
    bit          m_pend;
    logic [1:0]  m_sel;
    int unsigned m_pos;
    logic [15:0] m_cnt;
    int unsigned m_pcnt;
    int unsigned m_len;

    function automatic int unsigned half_of(input logic [1:0] s);
        int unsigned d;
        case (s)
            2'd0:    d = 4;
            2'd1:    d = 6;
            2'd2:    d = 8;
            default: d = 3;
        endcase
        return ((d / 2) == 0) ? 1 : (d / 2);
    endfunction

    task automatic model_reset();
        m_run  = 0;
        m_pend = 0;
        m_sel  = 2'd0;
        m_pos  = 0;
        m_cnt  = 16'd0;
        m_pcnt = 0;
        m_len  = 0;
    endtask

    task automatic model_step();
        int unsigned h;
        bit cancel;
        bit done;
        if (!m_run) begin
            if (st && !sp) begin
                m_run  = 1;
                m_pend = 0;
                m_sel  = sl;
                m_pos  = 0;
                m_pcnt = 0;
`ifdef RATE_BURST_EN
                m_len  = blen;
`else
                m_len  = 0;
`endif
            end
        end else begin
            h      = half_of(m_sel);
            cancel = m_pend && st && !sp;
            if (m_pos == 2 * h - 1) begin
                m_pcnt++;
                done = (m_len != 0) && (m_pcnt == m_len);
                m_pos = 0;
                if ((m_pend && !cancel) || done) begin
                    m_run  = 0;
                    m_pend = 0;
                end else begin
                    m_sel = sl;
                    if (cancel) m_pend = 0;
                    else if (sp) m_pend = 1;
                end
            end else begin
                m_pos++;
                if (m_pos == h) m_cnt++;
                if (cancel) m_pend = 0;
                else if (sp) m_pend = 1;
            end
        end
    endtask

    task automatic model_compare();
        int unsigned h;
        h = half_of(m_sel);
        check("rnd_running", 32'(running), 32'(m_run));
        check("rnd_clk_out", 32'(clk_out), 32'(m_run && (m_pos >= h)));
        check("rnd_tick", 32'(tick), 32'(m_run && (m_pos == h)));
        check("rnd_sel_active", 32'(sel_active), 32'(m_sel));
        check("rnd_tick_cnt", 32'(tick_cnt), 32'(m_cnt));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        st    = 1'b0;
        sp    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        st;
        logic        sp;
        logic [1:0]  sl;
        logic        run;
        logic        ck;
        logic        tk;
        logic [1:0]  sa;
        logic [15:0] tc;
    } vec_t;

    vec_t tv[33];

    initial begin
        int tcount;
        // Stimulus/expect table, one row per clk_in edge, all with DIV0=4, DIV1=6, DIV2=8.
        tv[0]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0};
        tv[1]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0};
        tv[2]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 2'd0, 16'd1};
        tv[3]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 2'd0, 16'd1};
        tv[4]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 2'd2, 16'd1};
        tv[5]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 2'd2, 16'd1};
        tv[6]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 2'd2, 16'd1};
        tv[7]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 2'd2, 16'd1};
        tv[8]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 2'd2, 16'd2};
        tv[9]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 2'd2, 16'd2};
        tv[10] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 2'd2, 16'd2};
        tv[11] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 2'd2, 16'd2};
        tv[12] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 2'd2, 16'd2};
        tv[13] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 2'd2, 16'd2};
        tv[14] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 2'd2, 16'd2};
        tv[15] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 2'd2, 16'd2};
        tv[16] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 2'd2, 16'd3};
        tv[17] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 2'd2, 16'd3};
        tv[18] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 2'd2, 16'd3};
        tv[19] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 2'd2, 16'd3};
        tv[20] = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 2'd2, 16'd3};
        tv[21] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd2, 16'd3};
        tv[22] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd2, 16'd3};
        tv[23] = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 2'd1, 16'd3};
        tv[24] = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 2'd1, 16'd3};
        tv[25] = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 2'd1, 16'd3};
        tv[26] = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 2'd1, 16'd4};
        tv[27] = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd1, 16'd4};
        tv[28] = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 2'd1, 16'd4};
        tv[29] = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 2'd1, 16'd4};
        tv[30] = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 2'd1, 16'd4};
        tv[31] = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 2'd1, 16'd4};
        tv[32] = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 2'd1, 16'd5};

        rst_n = 1'b0;
        st    = 1'b0;
        sp    = 1'b0;
        sl    = 2'd0;
        blen  = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_running", 32'(running), 32'd0);
        check("reset_clk_out", 32'(clk_out), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_sel_active", 32'(sel_active), 32'd0);
        check("reset_tick_cnt", 32'(tick_cnt), 32'd0);
        rst_n = 1'b1;

        // Directed table
        @(negedge clk);
        for (int i = 0; i < 33; i++) begin
            st = tv[i].st;
            sp = tv[i].sp;
            sl = tv[i].sl;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_running", i), 32'(running), 32'(tv[i].run));
            check($sformatf("vec%0d_clk_out", i), 32'(clk_out), 32'(tv[i].ck));
            check($sformatf("vec%0d_tick", i), 32'(tick), 32'(tv[i].tk));
            check($sformatf("vec%0d_sel_active", i), 32'(sel_active), 32'(tv[i].sa));
            check($sformatf("vec%0d_tick_cnt", i), 32'(tick_cnt), 32'(tv[i].tc));
        end
        st = 1'b0;
        sp = 1'b0;

        // Asynchronous reset while running: outputs clear without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_running", 32'(running), 32'd0);
        check("async_rst_clk_out", 32'(clk_out), 32'd0);
        check("async_rst_tick", 32'(tick), 32'd0);
        check("async_rst_sel_active", 32'(sel_active), 32'd0);
        check("async_rst_tick_cnt", 32'(tick_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_running", 32'(running), 32'd0);
            check("post_rst_clk_out", 32'(clk_out), 32'd0);
        end

        // Randomized run against the reference model
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            st   = ($urandom_range(0, 7) == 0);
            sp   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 5) == 0) sl = 2'($urandom_range(0, 3));
            blen = 8'($urandom_range(0, 5));
            @(posedge clk);
            model_step();
            #1;
            model_compare();
        end

        // tick_cnt wrap from 0xFFFF
        apply_reset();
        @(negedge clk);
        force dut.r_tick_cnt = 16'hFFFF;
        #1;
        release dut.r_tick_cnt;
        st = 1'b1;
        sp = 1'b0;
        sl = 2'd3;
        blen = 8'd0;
        @(posedge clk);
        #1;
        st = 1'b0;
        check("wrap_running", 32'(running), 32'd1);
        check("wrap_before", 32'(tick_cnt), 32'hFFFF);
        @(posedge clk);
        #1;
        check("wrap_tick", 32'(tick), 32'd1);
        check("wrap_clk_out", 32'(clk_out), 32'd1);
        check("wrap_after", 32'(tick_cnt), 32'd0);

`ifdef RATE_BURST_EN
        // Burst of 3 periods, then idle
        apply_reset();
        sl   = 2'd0;
        blen = 8'd3;
        st   = 1'b1;
        @(posedge clk);
        #1;
        st = 1'b0;
        tcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (tick) tcount++;
        end
        check("burst3_ticks", 32'(tcount), 32'd3);
        check("burst3_running", 32'(running), 32'd0);
        check("burst3_clk_out", 32'(clk_out), 32'd0);

        // burst_len 0 free-runs
        apply_reset();
        blen = 8'd0;
        st   = 1'b1;
        @(posedge clk);
        #1;
        st = 1'b0;
        tcount = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (tick) tcount++;
        end
        check("burst0_ticks", 32'(tcount), 32'd13);
        check("burst0_running", 32'(running), 32'd1);
`else
        tcount = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
